p1v_reset_seq: RTL and testbench
================================

Name: p1v_reset_seq

Overview:
- Reset sequencer between the board-level reset source and the virtual Propeller core.
- Takes the raw active-low reset from the USB serial bridge (fpga_resn) and the clock generator's PLL lock, then synchronizes and debounces them.
- Holds the core in reset until the clock is locked and the request has been stable for a minimum hold time.
- Drives the core's inp_resn glitch-free and counts reset events for debug and LED use.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for inp_resn and pll_locked (min 2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before the filtered reset request changes (min 1).
- HOLD_CYCLES, 1024, cycles resn stays low in WAIT after lock and request are both good (min 1).

Ports:
- clock_160  in  1  core clock from the clock generator; all logic on rising edge.
- reset  in  1  synchronous, active-high block reset.
- inp_resn  in  1  raw async active-low reset request from USB bridge (fpga_resn).
- pll_locked  in  1  async PLL lock indicator from clock generator.
- resn  out  1  registered active-low reset to p1v inp_resn.
- state  out  2  current FSM state: 00 ASSERT, 01 WAIT, 10 RUN; 11 unused.
- reset_count  out  8  number of RUN->ASSERT exits, saturating at 255.

Behaviour:
- Reset (reset=1 at clock edge): all synchronizer flops 0, req_f=0, debounce counter 0, hold counter 0, state=ASSERT, resn=0, reset_count=0.
- reset dominates every other event in the same cycle.
- Synchronizers: inp_resn and pll_locked each pass through SYNC_STAGES flops, giving req_s and lock_s.
- Debounce, inp_resn path only:
  - If req_s==req_f, the counter clears.
  - Otherwise the counter increments; on the cycle it equals DEBOUNCE_CYCLES-1, req_f<=req_s and the counter clears.
  - A mismatch run shorter than DEBOUNCE_CYCLES leaves req_f unchanged.
- lock_s is not debounced.
- good = req_f & lock_s.
- FSM (state register; resn is a separate flop loaded with next_state==RUN):
  - ASSERT: if good, go to WAIT with hold counter=0; otherwise stay.
  - WAIT:
    - If !good, go to ASSERT (hold counter cleared).
    - Else if hold counter==HOLD_CYCLES-1, go to RUN.
    - Else increment the hold counter.
  - RUN: if !good, go to ASSERT and reset_count<=min(reset_count+1,255); otherwise stay.
  - Encoding 11 (unreachable): go to ASSERT next cycle with resn=0.
- Latency, from the first clock edge sampling the new input value:
  - Rising inp_resn with lock stable: resn rises SYNC_STAGES+DEBOUNCE_CYCLES+HOLD_CYCLES+1 cycles later.
  - Falling inp_resn in RUN: resn falls SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles later.
  - Falling pll_locked in RUN: resn falls SYNC_STAGES+1 cycles later.
- Simultaneous lock loss and request drop in RUN: single ASSERT transition, reset_count increments once.
- Lock regained mid-WAIT after a loss restarts the full hold from ASSERT; there is no partial credit.
- resn never pulses high for less than one full RUN residency and never toggles outside a state transition.
- Counter widths: $clog2 of each parameter, minimum 1 bit; no wrap, since terminal compares are exact.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
- Power-up: reset=1 for 3 cycles, inp_resn=1, pll_locked=1. After reset drops, resn=0, state=00, reset_count=0, then state 01 and resn=1 exactly 15 cycles after the first sampled edge (lock/req already stable: debounce counted from reset release).
- Glitch reject: in RUN, inp_resn low for 3 cycles then high, so resn stays 1 and reset_count=0. Low for 4+ cycles, so resn=0 exactly 7 cycles after the first low sample, and reset_count=1.
- Lock loss: in RUN, pll_locked low for 1 cycle, so resn=0 exactly 3 cycles later, state 00, reset_count increments. On relock, resn=1 only after a full 8-cycle WAIT.
- Abort WAIT: enter WAIT, drop pll_locked at hold count 5, so state returns to 00 and resn stays 0 throughout. Restore lock, and WAIT restarts from count 0.
- Saturation: force 260 RUN->ASSERT cycles, so reset_count stops at 255.
- Reset mid-RUN: assert reset while resn=1, so the next edge gives resn=0, state=00, reset_count=0.

Source files
------------

// File: rtl/p1v_reset_seq.sv
// Reset sequencer for the virtual Propeller core: synchronizes and debounces the
// board reset request, gates it with PLL lock, and drives a glitch-free core reset.
module p1v_reset_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1024
) (
  input  logic       clock_160,
  input  logic       reset,
  input  logic       inp_resn,
  input  logic       pll_locked,
  output logic       resn,
  output logic [1:0] state,
  output logic [7:0] reset_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'b00,
    ST_WAIT   = 2'b01,
    ST_RUN    = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   req_s;
  logic                   lock_s;
  logic                   req_f;
  logic [DB_W-1:0]        db_cnt;
  logic                   good;

  state_t          state_q;
  state_t          state_d;
  logic [HD_W-1:0] hold_q;
  logic [HD_W-1:0] hold_d;
  logic            resn_d;
  logic [7:0]      count_d;

  always_ff @(posedge clock_160) begin
    if (reset) begin
      req_sync  <= '0;
      lock_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], inp_resn};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  // Only the request is debounced; lock loss must take effect immediately.
  always_ff @(posedge clock_160) begin
    if (reset) begin
      req_f  <= 1'b0;
      db_cnt <= '0;
    end else if (req_s == req_f) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      req_f  <= req_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign good = req_f & lock_s;

  always_ff @(posedge clock_160) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      hold_q      <= '0;
      resn        <= 1'b0;
      reset_count <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      resn        <= resn_d;
      reset_count <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_ASSERT: begin
        if (good) begin
          state_d = ST_WAIT;
          hold_d  = '0;
        end
      end
      ST_WAIT: begin
        if (!good) begin
          state_d = ST_ASSERT;
          hold_d  = '0;
        end else if (hold_q == HD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HD_W'(1);
        end
      end
      ST_RUN: begin
        if (!good) state_d = ST_ASSERT;
      end
      default: begin
        state_d = ST_ASSERT;
        hold_d  = '0;
      end
    endcase
  end

  // resn is registered from next-state so it can only change with a state transition.
  always_comb begin
    resn_d  = (state_d == ST_RUN);
    count_d = reset_count;
    if (state_q == ST_RUN && state_d == ST_ASSERT && reset_count != 8'hFF)
      count_d = reset_count + 8'd1;
  end

  assign state = state_q;

endmodule

// File: tb/tb_p1v_reset_seq.sv
// Self-checking bench for p1v_reset_seq: directed scenarios with spec latencies plus
// randomized input streams checked against a streak-based behavioural model.
module tb_p1v_reset_seq;

  localparam int S = 2;
  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       inp_resn;
  logic       pll_locked;
  logic       resn;
  logic [1:0] state;
  logic [7:0] reset_count;

  int n_tests = 0;
  int n_fail  = 0;

  p1v_reset_seq #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H)
  ) dut (
    .clock_160(clk),
    .reset(reset),
    .inp_resn(inp_resn),
    .pll_locked(pll_locked),
    .resn(resn),
    .state(state),
    .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  // Model: sampled-input history, request filtered by run length, and the FSM
  // reduced to "how many consecutive edges has good been true".
  bit       rq[$];
  bit       lq[$];
  bit       mf;
  bit       prev_s;
  int       run_len;
  int       streak;
  int       m_count;
  bit       m_resn;
  bit [1:0] m_state;

  always @(posedge clk) begin : model
    int n;
    bit rs, ls, good;
    if (reset) begin
      rq.delete();
      lq.delete();
      mf      = 1'b0;
      prev_s  = 1'b0;
      run_len = 0;
      streak  = 0;
      m_count = 0;
    end else begin
      n    = rq.size();
      rs   = (n >= S) ? rq[n-S] : 1'b0;
      ls   = (n >= S) ? lq[n-S] : 1'b0;
      good = mf & ls;
      if (good) begin
        if (streak <= H) streak++;
      end else begin
        if (streak > H && m_count < 255) m_count++;
        streak = 0;
      end
      if (rs == prev_s) run_len++;
      else begin
        run_len = 1;
        prev_s  = rs;
      end
      if (rs != mf && run_len >= D) mf = rs;
      rq.push_back(inp_resn);
      lq.push_back(pll_locked);
    end
    m_resn  = (streak > H);
    m_state = (streak == 0) ? 2'd0 : (streak <= H) ? 2'd1 : 2'd2;
  end

  task automatic wait_resn(input logic val, input int limit, output int cycles);
    bit done = 1'b0;
    cycles = -1;
    for (int i = 1; i <= limit && !done; i++) begin
      @(negedge clk);
      if (resn === val) begin
        cycles = i;
        done   = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inp_resn = 1'b1; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (resn !== 1'b0) begin n_fail++; $display("FAIL reset_resn: got %b want 0", resn); end
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
    n_tests++; if (reset_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", reset_count); end
  endtask

  task automatic test_power_up();
    int first_wait = -1;
    int first_run  = -1;
    int bad        = 0;
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resn !== m_resn || state !== m_state) bad++;
      if (state === 2'b01 && first_wait < 0) first_wait = k;
      if (resn === 1'b1 && first_run < 0) first_run = k;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL power_up_model: %0d cycles differ, want 0", bad); end
    n_tests++; if (first_wait != 7) begin n_fail++; $display("FAIL power_up_wait: WAIT at cycle %0d want 7", first_wait); end
    n_tests++; if (first_run != 15) begin n_fail++; $display("FAIL power_up_latency: resn rose at cycle %0d want 15", first_run); end
    n_tests++; if (reset_count !== 8'd0) begin n_fail++; $display("FAIL power_up_count: got %0d want 0", reset_count); end
  endtask

  task automatic test_glitch();
    int dropped = 0;
    int c;
    inp_resn = 1'b0;
    repeat (3) @(negedge clk);
    inp_resn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resn !== 1'b1) dropped++;
    end
    n_tests++; if (dropped != 0) begin n_fail++; $display("FAIL glitch_reject: resn low %0d cycles want 0", dropped); end
    n_tests++; if (reset_count !== 8'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", reset_count); end
    inp_resn = 1'b0;
    wait_resn(1'b0, 30, c);
    n_tests++; if (c != 7) begin n_fail++; $display("FAIL req_fall_latency: got %0d want 7", c); end
    n_tests++; if (reset_count !== 8'd1) begin n_fail++; $display("FAIL req_fall_count: got %0d want 1", reset_count); end
    inp_resn = 1'b1;
    wait_resn(1'b1, 100, c);
    n_tests++; if (c != 15) begin n_fail++; $display("FAIL req_rise_latency: got %0d want 15", c); end
  endtask

  task automatic test_lock_loss();
    int c;
    int waits = 0;
    bit rose  = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    wait_resn(1'b0, 10, c);
    n_tests++; if (c + 1 != 3) begin n_fail++; $display("FAIL lock_fall_latency: got %0d want 3", c + 1); end
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL lock_fall_state: got %b want 00", state); end
    n_tests++; if (reset_count !== 8'd2) begin n_fail++; $display("FAIL lock_fall_count: got %0d want 2", reset_count); end
    for (int k = 0; k < 40 && !rose; k++) begin
      @(negedge clk);
      if (state === 2'b01) waits++;
      if (resn === 1'b1) rose = 1'b1;
    end
    n_tests++; if (!rose || waits != H) begin n_fail++; $display("FAIL relock_wait: rose=%0d wait=%0d want rose=1 wait=%0d", rose, waits, H); end
  endtask

  task automatic test_abort_wait();
    int c;
    int waits   = 0;
    int hi      = 0;
    bit entered = 1'b0;
    bit rose    = 1'b0;
    pll_locked = 1'b0;
    wait_resn(1'b0, 10, c);
    repeat (5) @(negedge clk);
    pll_locked = 1'b1;
    for (int k = 0; k < 10 && !entered; k++) begin
      @(negedge clk);
      if (state === 2'b01) entered = 1'b1;
    end
    n_tests++; if (!entered) begin n_fail++; $display("FAIL abort_enter_wait: state %b want 01", state); end
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resn !== 1'b0 || state === 2'b10) hi++;
    end
    n_tests++; if (hi != 0 || state !== 2'b00) begin n_fail++; $display("FAIL abort_wait: resn/RUN %0d cycles, state %b want 0, 00", hi, state); end
    n_tests++; if (reset_count !== 8'd3) begin n_fail++; $display("FAIL abort_count: got %0d want 3", reset_count); end
    pll_locked = 1'b1;
    for (int k = 0; k < 40 && !rose; k++) begin
      @(negedge clk);
      if (state === 2'b01) waits++;
      if (resn === 1'b1) rose = 1'b1;
    end
    n_tests++; if (!rose || waits != H) begin n_fail++; $display("FAIL abort_rehold: rose=%0d wait=%0d want rose=1 wait=%0d", rose, waits, H); end
  endtask

  task automatic test_saturation();
    int c1, c2;
    int timeouts = 0;
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      wait_resn(1'b0, 10, c1);
      wait_resn(1'b1, 40, c2);
      if (c1 < 0 || c2 < 0) timeouts++;
    end
    n_tests++; if (timeouts != 0) begin n_fail++; $display("FAIL sat_cycles: %0d timeouts want 0", timeouts); end
    n_tests++; if (reset_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d want 255", reset_count); end
    n_tests++; if (reset_count !== 8'(m_count)) begin n_fail++; $display("FAIL sat_model: got %0d want %0d", reset_count, m_count); end
  endtask

  task automatic test_reset_mid_run();
    n_tests++; if (resn !== 1'b1) begin n_fail++; $display("FAIL mid_run_pre: resn %b want 1", resn); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++; if (resn !== 1'b0 || state !== 2'b00 || reset_count !== 8'd0)
      begin n_fail++; $display("FAIL mid_run_reset: resn=%b state=%b count=%0d want 0 00 0", resn, state, reset_count); end
  endtask

  task automatic test_random();
    int hold_r = 0;
    int hold_l = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      n_tests++;
      if (resn !== m_resn || state !== m_state || reset_count !== 8'(m_count)) begin
        n_fail++;
        $display("FAIL random_cycle%0d: resn=%b state=%b count=%0d want %b %b %0d",
                 k, resn, state, reset_count, m_resn, m_state, m_count);
      end
      if (hold_r == 0) begin
        inp_resn = ($urandom_range(0, 3) != 0);
        hold_r   = $urandom_range(1, 24);
      end else hold_r--;
      if (hold_l == 0) begin
        pll_locked = ($urandom_range(0, 4) != 0);
        hold_l     = $urandom_range(1, 30);
      end else hold_l--;
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_lock_loss();
    test_abort_wait();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
